// File: rtl/bpu_override_pipe_if.sv
// rtl/bpu_override_pipe_if.sv - fetch-block handoff from the prediction pipe to the FTQ
// A block is taken by the FTQ when o_pred_vld && i_ftq_rdy && !o_override.
interface bpu_override_pipe_if #(
   parameter int XLEN    = 64,
   parameter int SW      = 2,
   parameter int GHR_LEN = 64
);
   logic               o_pred_vld;
   logic               i_ftq_rdy;
   logic [XLEN-1:0]    o_pred_start;
   logic [XLEN-1:0]    o_pred_end;
   logic [XLEN-1:0]    o_pred_next;
   logic               o_pred_taken;
   logic [SW-1:0]      o_pred_src;
   logic [GHR_LEN-1:0] o_pred_ghr;

   modport master (
      output o_pred_vld, o_pred_start, o_pred_end, o_pred_next,
      output o_pred_taken, o_pred_src, o_pred_ghr,
      input  i_ftq_rdy
   );

   modport slave (
      input  o_pred_vld, o_pred_start, o_pred_end, o_pred_next,
      input  o_pred_taken, o_pred_src, o_pred_ghr,
      output i_ftq_rdy
   );
endinterface

// File: rtl/bpu_override_pipe.sv
// rtl/bpu_override_pipe.sv - N-stage branch prediction pipe with late-stage override
// Later predictors may rewrite their block in place, flush younger stages and repair history.
module bpu_override_pipe #(
   parameter int              XLEN        = 64,
   parameter int              STAGES      = 3,
   parameter int              FETCH_BYTES = 32,
   parameter int              GHR_LEN     = 64,
   parameter logic [XLEN-1:0] INIT_PC     = 64'h80000000,
   parameter int              SW          = $clog2(STAGES+1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_squash_vld,
   input  logic [XLEN-1:0]        i_squash_pc,
   input  logic                   i_commit_vld,
   input  logic                   i_commit_taken,
   output logic [XLEN-1:0]        o_lookup_pc,
   output logic [GHR_LEN-1:0]     o_lookup_ghr,
   output logic                   o_lookup_fire,
   input  logic [STAGES-1:0]      i_stg_hit,
   input  logic [STAGES-1:0]      i_stg_taken,
   input  logic [STAGES*XLEN-1:0] i_stg_npc,
   input  logic [STAGES*XLEN-1:0] i_stg_fallthru,
   output logic                   o_override,
   bpu_override_pipe_if.master    ftq
);
   localparam int L = STAGES - 1;

   typedef struct packed {
      logic               vld;
      logic [XLEN-1:0]    start;
      logic [XLEN-1:0]    npc;
      logic [XLEN-1:0]    ft;
      logic               tkn;
      logic [SW-1:0]      src;
      logic [GHR_LEN-1:0] ghr;
   } ent_t;

   ent_t               stg_q [1:L];
   ent_t               stg_d [1:L];
   logic [XLEN-1:0]    base_q, base_d;
   logic [GHR_LEN-1:0] spec_q, spec_d;
   logic [GHR_LEN-1:0] arch_q, arch_d;

   logic [XLEN-1:0]    s0_npc, s0_ft;
   logic               s0_tkn;
   logic [SW-1:0]      s0_src;

   logic               ovr_any;
   int                 ovr_idx;
   logic [XLEN-1:0]    ovr_npc, ovr_ft;
   logic               ovr_tkn;
   logic [SW-1:0]      ovr_src;
   logic [GHR_LEN-1:0] ovr_ghr;

   logic               advance;
   logic               fire;
   logic               override;

   always_comb begin
      s0_npc = base_q + XLEN'(FETCH_BYTES);
      s0_ft  = base_q + XLEN'(FETCH_BYTES);
      s0_tkn = 1'b0;
      s0_src = '0;
      if (i_stg_hit[0]) begin
         s0_npc = i_stg_npc[XLEN-1:0];
         s0_ft  = i_stg_fallthru[XLEN-1:0];
         s0_tkn = i_stg_taken[0];
         s0_src = SW'(1);
      end
   end

   // Ascending scan so the oldest disagreeing stage is the one that wins.
   always_comb begin
      ovr_any = 1'b0;
      ovr_idx = 0;
      ovr_npc = '0;
      ovr_ft  = '0;
      ovr_tkn = 1'b0;
      ovr_src = '0;
      ovr_ghr = '0;
      for (int k = 1; k <= L; k++) begin
         if (stg_q[k].vld && i_stg_hit[k] &&
             ({i_stg_npc[k*XLEN +: XLEN], i_stg_fallthru[k*XLEN +: XLEN], i_stg_taken[k]} !=
              {stg_q[k].npc, stg_q[k].ft, stg_q[k].tkn})) begin
            ovr_any = 1'b1;
            ovr_idx = k;
            ovr_npc = i_stg_npc[k*XLEN +: XLEN];
            ovr_ft  = i_stg_fallthru[k*XLEN +: XLEN];
            ovr_tkn = i_stg_taken[k];
            ovr_src = SW'(k + 1);
            ovr_ghr = stg_q[k].ghr;
         end
      end
   end

   always_comb begin
      advance  = !stg_q[L].vld || ftq.i_ftq_rdy;
      arch_d   = i_commit_vld ? {arch_q[GHR_LEN-2:0], i_commit_taken} : arch_q;
      stg_d    = stg_q;
      base_d   = base_q;
      spec_d   = spec_q;
      fire     = 1'b0;
      override = 1'b0;
      if (i_squash_vld) begin
         for (int k = 1; k <= L; k++) stg_d[k].vld = 1'b0;
         base_d = i_squash_pc;
         spec_d = arch_d;
      end else if (ovr_any) begin
         // The whole pipe freezes; only the overridden entry and its younger stages change.
         override = 1'b1;
         for (int k = 1; k <= L; k++) begin
            if (k == ovr_idx) begin
               stg_d[k].npc = ovr_npc;
               stg_d[k].ft  = ovr_ft;
               stg_d[k].tkn = ovr_tkn;
               stg_d[k].src = ovr_src;
            end else if (k < ovr_idx) begin
               stg_d[k].vld = 1'b0;
            end
         end
         base_d = ovr_npc;
         spec_d = {ovr_ghr[GHR_LEN-2:0], ovr_tkn};
      end else if (advance) begin
         fire = 1'b1;
         for (int k = L; k >= 2; k--) stg_d[k] = stg_q[k-1];
         stg_d[1].vld   = 1'b1;
         stg_d[1].start = base_q;
         stg_d[1].npc   = s0_npc;
         stg_d[1].ft    = s0_ft;
         stg_d[1].tkn   = s0_tkn;
         stg_d[1].src   = s0_src;
         stg_d[1].ghr   = spec_q;
         base_d = s0_npc;
         if (i_stg_hit[0]) spec_d = {spec_q[GHR_LEN-2:0], s0_tkn};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base_q <= INIT_PC;
         spec_q <= '0;
         arch_q <= '0;
         for (int k = 1; k <= L; k++) stg_q[k] <= '0;
      end else begin
         base_q <= base_d;
         spec_q <= spec_d;
         arch_q <= arch_d;
         stg_q  <= stg_d;
      end
   end

   assign o_lookup_pc       = base_q;
   assign o_lookup_ghr      = spec_q;
   assign o_lookup_fire     = fire && !rst;
   assign o_override        = override && !rst;
   assign ftq.o_pred_vld    = stg_q[L].vld;
   assign ftq.o_pred_start  = stg_q[L].start;
   assign ftq.o_pred_end    = stg_q[L].ft;
   assign ftq.o_pred_next   = stg_q[L].npc;
   assign ftq.o_pred_taken  = stg_q[L].tkn;
   assign ftq.o_pred_src    = stg_q[L].src;
   assign ftq.o_pred_ghr    = stg_q[L].ghr;
endmodule

// File: tb/tb_bpu_override_pipe.sv
// tb/tb_bpu_override_pipe.sv - directed and random checks of bpu_override_pipe
// Reference: a queue of in-flight blocks (oldest first) updated from the block's rules.
module tb_bpu_override_pipe;
   localparam int XLEN = 64, STAGES = 3, FB = 32, GL = 64;
   localparam int SW = $clog2(STAGES+1), L = STAGES - 1;
   localparam logic [63:0] INIT = 64'h80000000;

   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   logic                   sq, commit, ct;
   logic [63:0]            sq_pc;
   logic [63:0]            lookup_pc, lookup_ghr;
   logic                   fire, ovr;
   logic [STAGES-1:0]      hit, tkn;
   logic [STAGES*64-1:0]   npc_v, ft_v;

   bpu_override_pipe_if #(.XLEN(XLEN), .SW(SW), .GHR_LEN(GL)) ftq ();

   bpu_override_pipe #(.XLEN(XLEN), .STAGES(STAGES), .FETCH_BYTES(FB), .GHR_LEN(GL),
                       .INIT_PC(INIT)) dut (
      .clk(clk), .rst(rst),
      .i_squash_vld(sq), .i_squash_pc(sq_pc),
      .i_commit_vld(commit), .i_commit_taken(ct),
      .o_lookup_pc(lookup_pc), .o_lookup_ghr(lookup_ghr), .o_lookup_fire(fire),
      .i_stg_hit(hit), .i_stg_taken(tkn), .i_stg_npc(npc_v), .i_stg_fallthru(ft_v),
      .o_override(ovr), .ftq(ftq)
   );

   typedef struct {
      bit          vld;
      logic [63:0] start, npc, ft;
      bit          tkn;
      int          src;
      logic [63:0] ghr;
   } blk_t;

   blk_t        pipe[$];
   logic [63:0] m_base, m_spec, m_arch;
   int          n_cmp = 0, n_err = 0;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rnd_pc();
      return INIT + 64'($urandom_range(0, 32767)) * 64'd32;
   endfunction

   task automatic model_reset();
      blk_t e;
      e = '{vld: 0, start: 0, npc: 0, ft: 0, tkn: 0, src: 0, ghr: 0};
      pipe.delete();
      for (int i = 0; i < L; i++) pipe.push_back(e);
      m_base = INIT; m_spec = 0; m_arch = 0;
   endtask

   task automatic idle_in();
      sq = 0; sq_pc = 0; commit = 0; ct = 0;
      hit = 0; tkn = 0; npc_v = 0; ft_v = 0;
      ftq.i_ftq_rdy = 1;
   endtask

   // Compare one cycle against the model, then advance the model past the clock edge.
   task automatic step();
      blk_t        e, nb;
      int          oi;
      bit          adv, exp_ovr, exp_fire;
      logic [63:0] arch_n;
      #1;
      oi = -1;
      for (int i = 0; i < L; i++) begin
         int k;
         k = L - i;
         if (oi < 0 && pipe[i].vld && hit[k] &&
             (npc_v[k*64 +: 64] !== pipe[i].npc || ft_v[k*64 +: 64] !== pipe[i].ft ||
              tkn[k] !== pipe[i].tkn))
            oi = i;
      end
      adv      = !pipe[0].vld || ftq.i_ftq_rdy;
      exp_ovr  = !sq && oi >= 0;
      exp_fire = !sq && oi < 0 && adv;
      chk("pred_vld", 64'(ftq.o_pred_vld), 64'(pipe[0].vld));
      if (pipe[0].vld) begin
         chk("pred_start", ftq.o_pred_start, pipe[0].start);
         chk("pred_end", ftq.o_pred_end, pipe[0].ft);
         chk("pred_next", ftq.o_pred_next, pipe[0].npc);
         chk("pred_taken", 64'(ftq.o_pred_taken), 64'(pipe[0].tkn));
         chk("pred_src", 64'(ftq.o_pred_src), 64'(pipe[0].src));
         chk("pred_ghr", ftq.o_pred_ghr, pipe[0].ghr);
      end
      if (ftq.o_pred_vld)
         chk("end_gt_start", 64'(ftq.o_pred_end > ftq.o_pred_start), 64'd1);
      chk("lookup_pc", lookup_pc, m_base);
      chk("lookup_ghr", lookup_ghr, m_spec);
      chk("override", 64'(ovr), 64'(exp_ovr));
      chk("lookup_fire", 64'(fire), 64'(exp_fire));

      arch_n = commit ? {m_arch[62:0], ct} : m_arch;
      if (sq) begin
         for (int i = 0; i < L; i++) begin e = pipe[i]; e.vld = 0; pipe[i] = e; end
         m_base = sq_pc;
         m_spec = arch_n;
      end else if (oi >= 0) begin
         int k;
         k = L - oi;
         e = pipe[oi];
         e.npc = npc_v[k*64 +: 64]; e.ft = ft_v[k*64 +: 64]; e.tkn = tkn[k]; e.src = k + 1;
         pipe[oi] = e;
         for (int i = oi + 1; i < L; i++) begin e = pipe[i]; e.vld = 0; pipe[i] = e; end
         m_base = pipe[oi].npc;
         m_spec = {pipe[oi].ghr[62:0], tkn[k]};
      end else if (adv) begin
         nb.vld = 1; nb.start = m_base; nb.ghr = m_spec;
         if (hit[0]) begin
            nb.npc = npc_v[63:0]; nb.ft = ft_v[63:0]; nb.tkn = tkn[0]; nb.src = 1;
            m_spec = {m_spec[62:0], tkn[0]};
         end else begin
            nb.npc = m_base + FB; nb.ft = m_base + FB; nb.tkn = 0; nb.src = 0;
         end
         void'(pipe.pop_front());
         pipe.push_back(nb);
         m_base = nb.npc;
      end
      m_arch = arch_n;
      @(negedge clk);
   endtask

   task automatic drive_rand();
      blk_t e;
      ftq.i_ftq_rdy = ($urandom_range(0, 3) != 0);
      sq     = ($urandom_range(0, 39) == 0);
      sq_pc  = rnd_pc();
      commit = 1'($urandom_range(0, 1));
      ct     = 1'($urandom_range(0, 1));
      hit[0] = 1'($urandom_range(0, 1));
      tkn[0] = 1'($urandom_range(0, 1));
      npc_v[63:0] = rnd_pc();
      ft_v[63:0]  = m_base + 64'(FB * $urandom_range(1, 2));
      for (int k = 1; k <= L; k++) begin
         e = pipe[L-k];
         hit[k] = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 1) begin
            npc_v[k*64 +: 64] = e.npc; ft_v[k*64 +: 64] = e.ft; tkn[k] = e.tkn;
         end else begin
            npc_v[k*64 +: 64] = rnd_pc();
            ft_v[k*64 +: 64]  = e.start + 64'(FB * $urandom_range(1, 2));
            tkn[k] = 1'($urandom_range(0, 1));
         end
      end
   endtask

   initial begin
      idle_in();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_vld", 64'(ftq.o_pred_vld), 64'd0);
      chk("rst_override", 64'(ovr), 64'd0);
      chk("rst_fire", 64'(fire), 64'd0);
      chk("rst_lookup_pc", lookup_pc, INIT);
      chk("rst_lookup_ghr", lookup_ghr, 64'd0);
      chk("rst_start", ftq.o_pred_start, 64'd0);
      chk("rst_next", ftq.o_pred_next, 64'd0);
      chk("rst_src", 64'(ftq.o_pred_src), 64'd0);
      rst = 0;

      // Fall-through stream after reset.
      step(); step();
      chk("ft_blk0", ftq.o_pred_start, 64'h80000000);
      chk("ft_src0", 64'(ftq.o_pred_src), 64'd0);
      step();
      chk("ft_blk1", ftq.o_pred_start, 64'h80000020);
      step();
      chk("ft_blk2", ftq.o_pred_start, 64'h80000040);

      // s0 hit, taken.
      sq = 1; sq_pc = 64'h80000000; step(); idle_in();
      hit[0] = 1; tkn[0] = 1; npc_v[63:0] = 64'h80001000; ft_v[63:0] = 64'h80000020;
      step(); idle_in();
      chk("s0_lookup", lookup_pc, 64'h80001000);
      chk("s0_ghr_lsb", 64'(lookup_ghr[0]), 64'd1);
      step();
      chk("s0_pred_next", ftq.o_pred_next, 64'h80001000);

      // Last-stage override against a fall-through block.
      sq = 1; sq_pc = 64'h80000000; step(); idle_in();
      step(); step();
      hit[2] = 1; tkn[2] = 1; npc_v[2*64 +: 64] = 64'h80002000; ft_v[2*64 +: 64] = 64'h80000020;
      #1 chk("s2_override", 64'(ovr), 64'd1);
      step(); idle_in();
      chk("s2_next", ftq.o_pred_next, 64'h80002000);
      chk("s2_src", 64'(ftq.o_pred_src), 64'd3);
      chk("s2_lookup", lookup_pc, 64'h80002000);
      step();
      chk("s2_bubble", 64'(ftq.o_pred_vld), 64'd0);
      step();

      // Five-cycle stall with an in-place override in the middle.
      ftq.i_ftq_rdy = 0;
      step(); step();
      hit[2] = 1; tkn[2] = 1; npc_v[2*64 +: 64] = 64'h80003000; ft_v[2*64 +: 64] = pipe[0].ft;
      step();
      hit = 0;
      chk("stall_next", ftq.o_pred_next, 64'h80003000);
      chk("stall_vld", 64'(ftq.o_pred_vld), 64'd1);
      step(); step();
      idle_in();
      step(); step(); step();

      // Squash with a same-cycle taken commit.
      sq = 1; sq_pc = 64'h80004000; commit = 1; ct = 1;
      step(); idle_in();
      chk("sq_lookup", lookup_pc, 64'h80004000);
      chk("sq_ghr", lookup_ghr, 64'd1);
      chk("sq_empty", 64'(ftq.o_pred_vld), 64'd0);
      step(); step();
      chk("sq_out", ftq.o_pred_start, 64'h80004000);

      // Squash beats a simultaneous stage-1 override.
      sq = 1; sq_pc = 64'h80005000;
      hit[1] = 1; tkn[1] = 1; npc_v[1*64 +: 64] = 64'h80006000; ft_v[1*64 +: 64] = 64'h80004040;
      #1 chk("sq_vs_ovr", 64'(ovr), 64'd0);
      step(); idle_in();
      chk("sq_vs_ovr_pc", lookup_pc, 64'h80005000);

      repeat (500) begin
         drive_rand();
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
